// File: rtl/program_counter_stack.sv
// Program counter and circular hardware return stack for the FRANK6000 core.
// All state is registered; pc, the stack and the return-address register update on the rising edge.
module program_counter_stack #(
    parameter int          PC_WIDTH     = 10,
    parameter int          STACK_DEPTH  = 4,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           PCw,
    input  logic                           jump,
    input  logic [1:0]                     j_mode,
    input  logic                           call,
    input  logic                           ret,
    input  logic [PC_WIDTH-1:0]            target,
    input  logic                           skip_cond,
    output logic [PC_WIDTH-1:0]            pc,
    output logic [$clog2(STACK_DEPTH):0]   stack_level,
    output logic                           stack_empty,
    output logic                           stack_full,
    output logic                           stack_ovf,
    output logic                           stack_unf
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_ra;
    logic [PTR_W-1:0]    r_wptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_ovf;
    logic                r_unf;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0] w_pc_inc1;
    logic [PC_WIDTH-1:0] w_pc_inc2;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PTR_W-1:0]    w_rd_ptr;
    logic                w_push;
    logic                w_pop;
    logic                w_is_full;
    logic                w_is_empty;

    assign w_pc_inc1  = r_pc + PC_WIDTH'(1);
    assign w_pc_inc2  = r_pc + PC_WIDTH'(2);
    assign w_rd_ptr   = r_wptr - PTR_W'(1);
    assign w_is_full  = (r_level == LVL_W'(STACK_DEPTH));
    assign w_is_empty = (r_level == LVL_W'(0));
    // A call wins over a simultaneous return, so push and pop never collide.
    assign w_push     = call & PCw;
    assign w_pop      = ret & ~w_push;

    // Next-pc source selection.
    always_comb begin
        w_pc_next = w_pc_inc1;
        case (j_mode)
            2'b00:   w_pc_next = w_pc_inc1;
            2'b01:   w_pc_next = jump ? target : w_pc_inc1;
            2'b10:   w_pc_next = r_ra;
            2'b11:   w_pc_next = skip_cond ? w_pc_inc2 : w_pc_inc1;
            default: w_pc_next = w_pc_inc1;
        endcase
    end

    // Return-stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack[r_wptr] <= w_pc_inc1;
        end
    end

    // PC, pointer, level, return-address register and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= PC_WIDTH'(RESET_VECTOR);
            r_ra    <= {PC_WIDTH{1'b0}};
            r_wptr  <= {PTR_W{1'b0}};
            r_level <= {LVL_W{1'b0}};
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (PCw) begin
                r_pc <= w_pc_next;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
                if (w_is_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_level <= r_level + LVL_W'(1);
                end
            end else if (w_pop) begin
                if (w_is_empty) begin
                    r_ra  <= {PC_WIDTH{1'b0}};
                    r_unf <= 1'b1;
                end else begin
                    r_wptr  <= w_rd_ptr;
                    r_ra    <= r_stack[w_rd_ptr];
                    r_level <= r_level - LVL_W'(1);
                end
            end
        end
    end

    assign pc          = r_pc;
    assign stack_level = r_level;
    assign stack_empty = w_is_empty;
    assign stack_full  = w_is_full;
    assign stack_ovf   = r_ovf;
    assign stack_unf   = r_unf;

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Program counter and hardware return stack for the FRANK6000 core.
- Sits directly downstream of the control unit and consumes its PCw, jump, j_mode, call and return strobes.
- Produces the instruction fetch address and latches return addresses for CALLS/RETRN.
- All updates are single-cycle and registered; there is no combinational path from the strobes to pc.

Parameters:
- PC_WIDTH, 10, width of pc, target and every stack entry.
- STACK_DEPTH, 4, number of return-stack entries (power of two, at least 2).
- RESET_VECTOR, 0, value loaded into pc on reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- PCw  in  1  pc write enable from the control unit.
- jump  in  1  jump qualifier from the control unit.
- j_mode  in  2  next-pc source select.
- call  in  1  push return address (valid only together with PCw).
- return  in  1  pop stack top into the return-address register.
- target  in  PC_WIDTH  absolute jump/call address from the instruction literal field.
- skip_cond  in  1  condition for j_mode 11, from the STATUS logic.
- pc  out  PC_WIDTH  current fetch address.
- stack_level  out  clog2(STACK_DEPTH)+1  number of valid stack entries.
- stack_empty  out  1  stack_level == 0.
- stack_full  out  1  stack_level == STACK_DEPTH.
- stack_ovf  out  1  sticky overflow flag.
- stack_unf  out  1  sticky underflow flag.

Behaviour:
- Reset (synchronous; overrides every other input in the same cycle):
  - pc = RESET_VECTOR.
  - stack_level = 0; write pointer = 0.
  - ra_q (internal return-address register) = 0.
  - stack_ovf = 0; stack_unf = 0.
  - Stack RAM contents are don't-care.
- PC update: pc changes only when PCw=1. Next value by j_mode:
  - 00: pc+1.
  - 01: target if jump=1, else pc+1.
  - 10: ra_q.
  - 11: pc+2 if skip_cond=1, else pc+1.
- PC arithmetic is modulo 2^PC_WIDTH. The all-ones value +1 wraps to 0; +2 from all-ones gives 1.
- PCw=0: pc holds regardless of jump, j_mode, target or skip_cond.
- Call (call=1 and PCw=1):
  - Write pc+1 (modulo) to the entry at the write pointer, then increment the pointer modulo STACK_DEPTH.
  - pc takes its j_mode selection in the same cycle; CALLS uses j_mode=01 with jump=1.
- Call with PCw=0: ignored, no push.
- Overflow (push while stack_full):
  - The push still occurs and overwrites the oldest entry (circular buffer).
  - stack_level stays at STACK_DEPTH; stack_ovf sets.
- Return (return=1, independent of PCw):
  - Decrement the pointer modulo STACK_DEPTH, then copy that entry to ra_q the same edge.
  - stack_level decrements.
  - The following cycle (CYCLE1 of RETRN) applies j_mode=10 with PCw=1 and loads pc from ra_q.
- Underflow (return while stack_empty):
  - ra_q = 0; pointer and stack_level unchanged; stack_unf sets.
- Call and return asserted in the same cycle: the call is processed, the return is ignored, and ra_q is unchanged.
- Sticky flags clear only on rst.
- The stack is readable and writable in the same cycle, with no read-during-write hazard, because push and pop are mutually exclusive.
- rst asserted mid CALLS/RETRN sequence: the sequence is aborted and the reset values apply on the next edge. A pending ra_q load is lost.
- Latency: every output reflects the effect of the inputs one clock after the sampling edge.

Test Plan:
- Reset, then 5 cycles with PCw=1, j_mode=00 -> pc = 0,1,2,3,4,5; stack_empty=1; flags 0.
- pc=0x3FF, PCw=1, j_mode=00 -> pc=0x000. Then pc=0x3FF, j_mode=11, skip_cond=1 -> pc=0x001.
- pc=0x010: CALLS (call, jump, j_mode=01, target=0x200, PCw) -> pc=0x200, stack_level=1. Then return pulse, next cycle j_mode=10 with PCw -> pc=0x011, stack_empty=1.
- Nested calls to depth 5 (STACK_DEPTH=4) -> stack_ovf=1, stack_level=4. Four returns then yield the last four return addresses, newest first.
- Return with an empty stack -> stack_unf=1, ra_q=0; the subsequent j_mode=10 load gives pc=0.
- Assert rst between the return pulse and the j_mode=10 cycle -> pc=RESET_VECTOR, stack_level=0, flags 0; the later j_mode=10 load gives 0.
